apb_mem_slave: RTL and testbench
================================

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL provide parameter ADDR_WIDTH, default 4, meaning the PADDAR width in bits.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 8, meaning the PWDATA/PRDATA width; legal values are multiples of 8, from 8 to 32.
REQ-003 The block SHALL provide parameter DEPTH, default 16, meaning the number of storage words; DEPTH SHALL be at most 2**ADDR_WIDTH.
REQ-004 The block SHALL provide parameter WAIT_CYCLES, default 0, meaning PREADY-low ACCESS cycles per transfer; legal range is 0..15.
REQ-005 The block SHALL have one clock, PCLK, and the reset SHALL be asynchronous and active-high, named RESET.
REQ-006 PCLK  input  1  clock; all state SHALL update on the rising edge.
REQ-007 RESET  input  1  asynchronous active-high reset.
REQ-008 PSLEx  input  1  slave select.
REQ-009 PENABLE  input  1  ACCESS phase indicator.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDAR  input  ADDR_WIDTH  word address.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PRDATA  output  DATA_WIDTH  read data, registered.
REQ-014 PREADY  output  1  transfer completion, registered.
REQ-015 PSLVERR  output  1  transfer error, registered; it SHALL be valid only while PREADY=1.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, WAIT and ACCESS_DONE.
- IDLE -> SETUP: on sampling PSLEx=1 and PENABLE=0.
REQ-017 At the SETUP edge, the block SHALL capture PADDAR, PWRITE and PWDATA, and SHALL clear the wait counter.
REQ-018 From SETUP, the block SHALL go to ACCESS_DONE if WAIT_CYCLES=0, else to WAIT.
- The ACCESS phase SHALL last exactly WAIT_CYCLES+1 cycles.
- PREADY SHALL be high only in the last of those cycles.
REQ-019 In WAIT, the block SHALL increment the counter on each edge sampling PSLEx=1 and PENABLE=1.
- It SHALL go to ACCESS_DONE when the counter reaches WAIT_CYCLES-1.
REQ-020 In ACCESS_DONE, PREADY SHALL be 1 for exactly one cycle.
- The block SHALL then return to IDLE.
- If PSLEx=1 and PENABLE=0 is sampled on that same edge, it SHALL go to SETUP instead (back-to-back transfer).
REQ-021 A write SHALL commit to mem[addr] on the edge ending the PREADY=1 cycle; it SHALL NOT commit earlier.
REQ-022 For a read, PRDATA SHALL equal mem[addr] during the PREADY=1 cycle and SHALL hold its value otherwise.
REQ-023 An address at or above DEPTH SHALL produce PSLVERR=1 with PREADY=1.
- A write to such an address SHALL be discarded.
- A read from such an address SHALL return PRDATA=0.
REQ-024 PENABLE=1 sampled in IDLE without a preceding SETUP SHALL complete with PREADY=1 and PSLVERR=1, with no memory access.
REQ-025 If PSLEx drops in SETUP or WAIT, the transfer SHALL abort.
- The block SHALL return to IDLE.
- There SHALL be no write and no PREADY pulse.
REQ-026 A read of an address in the same cycle its write commits SHALL return the old data; reads after the commit edge SHALL return the new data.

Reset
REQ-027 Asserting RESET SHALL immediately force the FSM to IDLE, PREADY=0, PSLVERR=0 and PRDATA=0, and SHALL clear the wait counter.
REQ-028 Reset SHALL clear every memory word to 0.
REQ-029 Reset asserted mid-transfer SHALL abort that transfer with no write.
REQ-030 The first SETUP sampled after RESET deasserts SHALL be accepted normally.

Configuration
REQ-031 The macro APB_PSTRB_EN SHALL control byte-strobe support.
REQ-032 With APB_PSTRB_EN defined:
- The block SHALL add input PSTRB, DATA_WIDTH/8 bits wide, captured at SETUP.
- A write SHALL update only the bytes whose strobe bit is 1.
- A read with PSTRB not equal to 0 SHALL give PSLVERR=1 and PRDATA=0.
REQ-033 With APB_PSTRB_EN undefined, the PSTRB port SHALL be absent and every write SHALL update the full word.

Verification
REQ-034 WAIT_CYCLES=0: write 0xA5 to addr 3, then read addr 3 -> each transfer has 2 cycles with PREADY high in cycle 2; the read gives PRDATA=0xA5 and PSLVERR=0.
REQ-035 WAIT_CYCLES=3: read addr 0 after reset -> PREADY stays low for 3 ACCESS cycles and is high in the 4th; PRDATA=0x00.
REQ-036 DEPTH=12, ADDR_WIDTH=4: write 0x5A to addr 14, then read addr 14 -> both give PSLVERR=1 with PREADY=1; the read gives PRDATA=0; mem is unchanged.
REQ-037 PSLEx dropped during WAIT of a write of 0xFF to addr 2 -> no PREADY pulse; a later read of addr 2 gives 0x00.
REQ-038 APB_PSTRB_EN, DATA_WIDTH=32: write 0x11223344 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5 -> the read gives 0x11BB33DD.
REQ-039 RESET asserted in WAIT of a write to addr 1 -> outputs are 0 at once; a read of addr 1 after reset gives 0x00.

Source files
------------

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave fronting a DEPTH-word register memory.
// Ports: PCLK, RESET (async, active-high); APB request PSLEx, PENABLE,
//   PWRITE, PADDAR, PWDATA (+ PSTRB when APB_PSTRB_EN is defined);
//   registered responses PRDATA, PREADY, PSLVERR.
// Build option: define APB_PSTRB_EN to add per-byte write strobes.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    RESET,
  input  logic                    PSLEx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDAR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0] LP_WLAST =
    4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam bit LP_NOWAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_ACCESS_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_access;
  logic                  w_cap;
  logic                  w_perr;
  logic                  w_cap_err;
  logic                  w_err;
  logic                  w_write;
  logic                  w_done;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [NB-1:0]         w_strb;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_setup  = PSLEx & ~PENABLE;
  assign w_access = PSLEx & PENABLE;

`ifdef APB_PSTRB_EN
  assign w_strb    = PSTRB;
  // a read carrying strobes is rejected
  assign w_cap_err = ({1'b0, PADDAR} >= LP_DEPTH)
                   | (~PWRITE & (|PSTRB));
`else
  assign w_strb    = '1;
  assign w_cap_err = ({1'b0, PADDAR} >= LP_DEPTH);
`endif

  // The transfer that completes next: with no wait cycles it is
  // the one being captured on this very edge.
  assign w_addr  = w_cap ? PADDAR    : r_addr;
  assign w_write = w_cap ? PWRITE    : r_write;
  assign w_err   = w_cap ? w_cap_err : (r_err | w_perr);
  assign w_done  = (w_next == ST_ACCESS_DONE);
  assign w_rdata = w_err ? '0 : r_mem[w_addr];

  // Writes land on the edge that closes the PREADY cycle.
  assign w_commit = (r_state == ST_ACCESS_DONE)
                  & r_write & ~r_err;

  // SETUP is the master's setup cycle; it ends on the edge that
  // samples it, so the register resolves it straight into its
  // successor and never rests there.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_perr = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_cap = 1'b1;
          if (LP_NOWAIT) w_next = ST_ACCESS_DONE;
          else           w_next = ST_WAIT;
        end else if (w_access) begin
          w_perr = 1'b1;
          w_next = ST_ACCESS_DONE;
        end
      end
      ST_WAIT: begin
        if (!PSLEx)
          w_next = ST_IDLE;
        else if (PENABLE && r_cnt == LP_WLAST)
          w_next = ST_ACCESS_DONE;
      end
      ST_ACCESS_DONE: begin
        if (w_setup) begin
          w_cap = 1'b1;
          if (LP_NOWAIT) w_next = ST_ACCESS_DONE;
          else           w_next = ST_WAIT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      r_state <= w_next;
      PREADY  <= w_done;
      PSLVERR <= w_done & w_err;
      if (w_cap) begin
        r_addr  <= PADDAR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_strb  <= w_strb;
        r_err   <= w_cap_err;
        r_cnt   <= '0;
      end else begin
        // orphan ACCESS: flag it so nothing gets written
        if (w_perr) r_err <= 1'b1;
        if (r_state == ST_WAIT && w_access)
          r_cnt <= r_cnt + 4'd1;
      end
      if (w_done && !w_perr && !w_write)
        PRDATA <= w_rdata;
    end
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < NB; b++)
        if (r_strb[b])
          r_mem[r_addr][b*8 +: 8] <= r_wdata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed bench for apb_mem_slave.
// Two instances: A (DEPTH 12, no wait), B (DEPTH 16, 3 waits).
module tb_apb_mem_slave;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    psel;
  logic          pen;
  logic          pwr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
`ifdef APB_PSTRB_EN
  logic [3:0]    pstrb;
`endif
  logic [DW-1:0] prdata [2];
  logic          pready [2];
  logic          pslverr [2];

  always #5 PCLK = ~PCLK;

  apb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(12), .WAIT_CYCLES(0)
  ) u_a (
    .PCLK(PCLK), .RESET(RESET),
    .PSLEx(psel[0]), .PENABLE(pen), .PWRITE(pwr),
    .PADDAR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(16), .WAIT_CYCLES(3)
  ) u_b (
    .PCLK(PCLK), .RESET(RESET),
    .PSLEx(psel[1]), .PENABLE(pen), .PWRITE(pwr),
    .PADDAR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1])
  );

  // transaction-level model
  int            depth [2] = '{12, 16};
  int            wc [2]    = '{0, 3};
  logic [DW-1:0] mm [2][16];
  logic          e_rdy [2];
  logic          e_err [2];
  logic [DW-1:0] e_rd [2];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endfunction

  always @(negedge PCLK) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pready%0d", k),
          32'(pready[k]), 32'(e_rdy[k]));
      chk($sformatf("pslverr%0d", k),
          32'(pslverr[k]), 32'(e_err[k]));
      chk($sformatf("prdata%0d", k), prdata[k], e_rd[k]);
    end
  end

  task automatic clr_exp();
    for (int k = 0; k < 2; k++) begin
      e_rdy[k] = 1'b0;
      e_err[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
    clr_exp();
  endtask

  task automatic idle();
    step();
    psel = '0;
    pen  = 1'b0;
  endtask

  // One transfer on instance k. stop_at aborts in that ACCESS
  // cycle (drop PSLEx, or assert RESET when use_rst is set).
  task automatic xfer(input int k, input bit wr,
                      input int addr, input logic [31:0] data,
                      input logic [3:0] strb, input int stop_at,
                      input bit use_rst);
    logic err;
    step();
    psel    = '0;
    psel[k] = 1'b1;
    pen     = 1'b0;
    pwr     = wr;
    paddr   = addr[AW-1:0];
    pwdata  = data;
`ifdef APB_PSTRB_EN
    pstrb   = strb;
`endif
    err = (addr >= depth[k]);
`ifdef APB_PSTRB_EN
    if (!wr && strb != 4'h0) err = 1'b1;
`endif
    for (int i = 0; i <= wc[k]; i++) begin
      step();
      if (i == stop_at) begin
        psel = '0;
        pen  = 1'b0;
        if (use_rst) begin
          RESET = 1'b1;
          for (int j = 0; j < 2; j++) begin
            e_rd[j] = '0;
            for (int a = 0; a < 16; a++) mm[j][a] = '0;
          end
        end
        return;
      end
      pen = 1'b1;
      if (i == wc[k]) begin
        e_rdy[k] = 1'b1;
        e_err[k] = err;
        if (!wr) e_rd[k] = err ? '0 : mm[k][addr];
      end
    end
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mm[k][addr][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // ACCESS without a preceding SETUP
  task automatic orphan(input int k);
    step();
    psel    = '0;
    psel[k] = 1'b1;
    pen     = 1'b1;
    pwr     = 1'b1;
    paddr   = 4'd3;
    pwdata  = 32'hDEAD_BEEF;
    step();
    psel     = '0;
    pen      = 1'b0;
    e_rdy[k] = 1'b1;
    e_err[k] = 1'b1;
  endtask

  initial begin
    psel   = '0;
    pen    = 1'b0;
    pwr    = 1'b0;
    paddr  = '0;
    pwdata = '0;
`ifdef APB_PSTRB_EN
    pstrb  = '0;
`endif
    clr_exp();
    for (int j = 0; j < 2; j++) begin
      e_rd[j] = '0;
      for (int a = 0; a < 16; a++) mm[j][a] = '0;
    end
    RESET = 1'b1;
    step();
    step();
    #1;
    chk("rst pready", 32'(pready[0]), 32'd0);
    chk("rst prdata", prdata[1], 32'd0);
    RESET = 1'b0;

    // write then read, no waits
    xfer(0, 1, 3, 32'hA5, 4'hF, -1, 0);
    chk("nw wr rdy", 32'(pready[0]), 32'd1);
    xfer(0, 0, 3, 32'h0, 4'hF, -1, 0);
    chk("nw rd data", prdata[0], 32'hA5);
    chk("nw rd err", 32'(pslverr[0]), 32'd0);
    idle();

    // 3-wait read of a fresh word
    xfer(1, 0, 0, 32'h0, 4'hF, -1, 0);
    chk("w3 rd rdy", 32'(pready[1]), 32'd1);
    chk("w3 rd data", prdata[1], 32'h0);

    // out-of-range on DEPTH 12
    xfer(0, 1, 14, 32'h5A, 4'hF, -1, 0);
    chk("oor wr err", 32'(pslverr[0]), 32'd1);
    xfer(0, 0, 14, 32'h0, 4'hF, -1, 0);
    chk("oor rd err", 32'(pslverr[0]), 32'd1);
    chk("oor rd data", prdata[0], 32'h0);
    xfer(0, 0, 6, 32'h0, 4'hF, -1, 0);
    xfer(0, 0, 3, 32'h0, 4'hF, -1, 0);
    chk("oor keep", prdata[0], 32'hA5);

    // edges of the address range
    xfer(0, 1, 11, 32'hC3, 4'hF, -1, 0);
    xfer(0, 0, 11, 32'h0, 4'hF, -1, 0);
    chk("last a", prdata[0], 32'hC3);
    xfer(0, 1, 12, 32'h66, 4'hF, -1, 0);
    xfer(0, 0, 12, 32'h0, 4'hF, -1, 0);
    chk("first bad", 32'(pslverr[0]), 32'd1);
    xfer(1, 1, 15, 32'h1234_5678, 4'hF, -1, 0);
    xfer(1, 0, 15, 32'h0, 4'hF, -1, 0);
    chk("last b", prdata[1], 32'h1234_5678);

    // PSLEx dropped while waiting
    xfer(1, 1, 2, 32'hFF, 4'hF, 1, 0);
    idle();
    xfer(1, 0, 2, 32'h0, 4'hF, -1, 0);
    chk("abort rd", prdata[1], 32'h0);

    // orphan ACCESS
    idle();
    orphan(0);
    chk("orph err", 32'(pslverr[0]), 32'd1);
    idle();
    xfer(0, 0, 3, 32'h0, 4'hF, -1, 0);
    chk("orph keep", prdata[0], 32'hA5);

    // reset in WAIT of a write
    xfer(1, 1, 1, 32'h77, 4'hF, -1, 0);
    xfer(1, 0, 1, 32'h0, 4'hF, -1, 0);
    chk("pre rst", prdata[1], 32'h77);
    xfer(1, 1, 1, 32'h99, 4'hF, 1, 1);
    #1;
    chk("async a", prdata[0], 32'h0);
    chk("async b", prdata[1], 32'h0);
    chk("async rdy", 32'(pready[1]), 32'd0);
    step();
    RESET = 1'b0;
    xfer(1, 0, 1, 32'h0, 4'hF, -1, 0);
    chk("post rst b", prdata[1], 32'h0);
    xfer(0, 0, 3, 32'h0, 4'hF, -1, 0);
    chk("post rst a", prdata[0], 32'h0);

`ifdef APB_PSTRB_EN
    xfer(0, 1, 5, 32'h1122_3344, 4'hF, -1, 0);
    xfer(0, 1, 5, 32'hAABB_CCDD, 4'h5, -1, 0);
    xfer(0, 0, 5, 32'h0, 4'h0, -1, 0);
    chk("strb merge", prdata[0], 32'h11BB_33DD);
    xfer(0, 0, 5, 32'h0, 4'h2, -1, 0);
    chk("strb rd err", 32'(pslverr[0]), 32'd1);
    chk("strb rd data", prdata[0], 32'h0);
`endif

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
